// File: rtl/trig_pwm_gen4.sv
// Four-channel PWM trigger generator. Duty values are staged on each update-toggle
// edge and applied at a frame boundary, or on the next clock while disabled.
module trig_pwm_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cap,
    input  logic       load,
    input  logic [7:0] val,
    input  logic [7:0] phase,
    output logic       pwm
);
    logic [7:0] stage_q;
    logic [7:0] active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q  <= 8'd0;
            active_q <= 8'd0;
            pwm      <= 1'b0;
        end else begin
            if (cap)
                stage_q <= val;
            // On a coincident capture, active takes the pre-capture staging value
            if (load)
                active_q <= stage_q;
            pwm <= en && (phase < active_q);
        end
    end
endmodule

module trig_pwm_gen4 #(
    parameter int PRESC_DIV = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       upd_toggle,
    input  logic [7:0] ch0_val,
    input  logic [7:0] ch1_val,
    input  logic [7:0] ch2_val,
    input  logic [7:0] ch3_val,
    output logic [3:0] pwm_out,
    output logic       frame_start,
    output logic       upd_ack,
    output logic       pending
);
    localparam int         NUM_CH     = 4;
    localparam logic [19:0] PRESC_LAST = 20'(PRESC_DIV - 1);

    logic [19:0]             presc;
    logic [7:0]              phase;
    logic                    tog_d;
    logic [NUM_CH-1:0][7:0]  ch_val;
    logic                    upd_edge;
    logic                    tick;
    logic                    wrap;
    logic                    load;

    assign ch_val   = {ch3_val, ch2_val, ch1_val, ch0_val};
    assign upd_edge = upd_toggle ^ tog_d;
    assign tick     = en && (presc == PRESC_LAST);
    assign wrap     = tick && (phase == 8'hFF);
    // While disabled there is no frame to protect, so staged values apply at once
    assign load     = pending && (en ? wrap : 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= 20'd0;
            phase       <= 8'd0;
            tog_d       <= 1'b0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            upd_ack     <= 1'b0;
        end else begin
            tog_d       <= upd_toggle;
            frame_start <= wrap;
            upd_ack     <= load;
            if (upd_edge)
                pending <= 1'b1;
            else if (load)
                pending <= 1'b0;
            if (!en) begin
                presc <= 20'd0;
                phase <= 8'd0;
            end else if (tick) begin
                presc <= 20'd0;
                phase <= phase + 8'd1;
            end else begin
                presc <= presc + 20'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        trig_pwm_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .cap   (upd_edge),
            .load  (load),
            .val   (ch_val[g]),
            .phase (phase),
            .pwm   (pwm_out[g])
        );
    end
endmodule

// File: tb/tb_trig_pwm_gen4.sv
// Bench for trig_pwm_gen4 with a 4-clock prescaler (1024-clock frames); per-frame
// expectations are queued when stimulus is applied and checked after each frame.
module tb_trig_pwm_gen4;
    localparam int PD    = 4;
    localparam int FRAME = 256 * PD;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       upd_toggle;
    logic [7:0] ch0_val, ch1_val, ch2_val, ch3_val;
    logic [3:0] pwm_out;
    logic       frame_start, upd_ack, pending;

    always #5 clk = ~clk;

    trig_pwm_gen4 #(.PRESC_DIV(PD)) dut (
        .clk(clk), .rst(rst), .en(en), .upd_toggle(upd_toggle),
        .ch0_val(ch0_val), .ch1_val(ch1_val), .ch2_val(ch2_val), .ch3_val(ch3_val),
        .pwm_out(pwm_out), .frame_start(frame_start), .upd_ack(upd_ack), .pending(pending)
    );

    typedef struct packed {
        logic [3:0][15:0] hi;
        logic [7:0]       acks;
        logic             pend;
    } frame_exp_t;

    frame_exp_t       sb[$];
    int               total = 0;
    int               bad = 0;
    logic [3:0][15:0] hi_cnt;
    int               first_low[4];
    int               ack_cnt, ack_idx, fs_cnt, fs_idx;
    logic             pend_end;

    function automatic frame_exp_t mk(input int h0, input int h1, input int h2, input int h3,
                                      input int acks, input logic pend);
        frame_exp_t r;
        r.hi   = {16'(h3), 16'(h2), 16'(h1), 16'(h0)};
        r.acks = 8'(acks);
        r.pend = pend;
        return r;
    endfunction

    // Samples one frame (starting on a frame_start cycle); optionally retoggles ch0 at two sample points
    task automatic measure_frame(input int ta, input logic [7:0] va, input int tb, input logic [7:0] vb);
        hi_cnt = '0;
        ack_cnt = 0; ack_idx = -1; fs_cnt = 0; fs_idx = -1;
        for (int c = 0; c < 4; c++) first_low[c] = -1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (pwm_out[c]) hi_cnt[c] = hi_cnt[c] + 16'd1;
                else if (first_low[c] < 0) first_low[c] = i;
            end
            if (frame_start) begin fs_cnt++; fs_idx = i; end
            if (upd_ack) begin ack_cnt++; ack_idx = i; end
            if (i == ta) begin ch0_val = va; upd_toggle = ~upd_toggle; end
            if (i == tb) begin ch0_val = vb; upd_toggle = ~upd_toggle; end
        end
        pend_end = pending;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; upd_toggle = 1'b0;
        ch0_val = 8'h00; ch1_val = 8'h00; ch2_val = 8'h00; ch3_val = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({pwm_out, frame_start, upd_ack, pending} !== 7'b0) begin
            bad++; $display("FAIL reset_hold got %b want 0000000", {pwm_out, frame_start, upd_ack, pending});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({pwm_out, frame_start, upd_ack, pending} !== 7'b0) begin
            bad++; $display("FAIL reset_release got %b want 0000000", {pwm_out, frame_start, upd_ack, pending});
        end
    endtask

    task automatic test_basic;
        frame_exp_t e;
        bit seen = 0;
        bit pend_low = 0;
        ch0_val = 8'h40; ch1_val = 8'h80; ch2_val = 8'h00; ch3_val = 8'hFF;
        en = 1'b1; upd_toggle = ~upd_toggle;
        sb.push_back(mk(256, 512, 0, 1020, 0, 1'b0));
        for (int i = 0; i < FRAME + 80 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1;
            else if (!pending) pend_low = 1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL basic_boundary got no frame_start want one within %0d clks", FRAME + 80); end
        total++;
        if (pend_low) begin bad++; $display("FAIL basic_pending_wait got pending=0 want 1 before boundary"); end
        total++;
        if ({upd_ack, pending} !== 2'b10) begin
            bad++; $display("FAIL basic_ack_at_boundary got ack,pend=%b want 10", {upd_ack, pending});
        end
        measure_frame(-1, 8'h00, -1, 8'h00);
        e = sb.pop_front();
        total++;
        if (hi_cnt !== e.hi) begin bad++; $display("FAIL basic_hi got %h want %h", hi_cnt, e.hi); end
        total++;
        if ({8'(ack_cnt), pend_end} !== {e.acks, e.pend}) begin
            bad++; $display("FAIL basic_ack got %0d/%b want %0d/%b", ack_cnt, pend_end, e.acks, e.pend);
        end
        total++;
        if (fs_cnt != 1 || fs_idx != FRAME - 1) begin
            bad++; $display("FAIL basic_frame_len got cnt=%0d idx=%0d want cnt=1 idx=%0d", fs_cnt, fs_idx, FRAME - 1);
        end
    endtask

    task automatic test_extremes;
        measure_frame(-1, 8'h00, -1, 8'h00);
        total++;
        if (hi_cnt[2] !== 16'd0) begin bad++; $display("FAIL ext_ch2_hi got %0d want 0", hi_cnt[2]); end
        total++;
        if (hi_cnt[3] !== 16'(FRAME - PD)) begin bad++; $display("FAIL ext_ch3_hi got %0d want %0d", hi_cnt[3], FRAME - PD); end
        total++;
        if (first_low[3] != FRAME - PD) begin bad++; $display("FAIL ext_ch3_low_pos got %0d want %0d", first_low[3], FRAME - PD); end
    endtask

    task automatic test_mid_frame;
        frame_exp_t e;
        sb.push_back(mk(256, 512, 0, 1020, 1, 1'b0));
        sb.push_back(mk(64, 512, 0, 1020, 0, 1'b0));
        for (int f = 0; f < 2; f++) begin
            if (f == 0) measure_frame(400, 8'h10, -1, 8'h00);
            else        measure_frame(-1, 8'h00, -1, 8'h00);
            e = sb.pop_front();
            total++;
            if (hi_cnt !== e.hi) begin bad++; $display("FAIL mid_hi f%0d got %h want %h", f, hi_cnt, e.hi); end
            total++;
            if ({8'(ack_cnt), pend_end} !== {e.acks, e.pend}) begin
                bad++; $display("FAIL mid_ack f%0d got %0d/%b want %0d/%b", f, ack_cnt, pend_end, e.acks, e.pend);
            end
            if (f == 0) begin
                total++;
                if (ack_idx != fs_idx || fs_idx != FRAME - 1) begin
                    bad++; $display("FAIL mid_ack_align got ack@%0d fs@%0d want both %0d", ack_idx, fs_idx, FRAME - 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        frame_exp_t e;
        sb.push_back(mk(64, 512, 0, 1020, 1, 1'b0));
        sb.push_back(mk(384, 512, 0, 1020, 0, 1'b0));
        for (int f = 0; f < 2; f++) begin
            if (f == 0) measure_frame(300, 8'h50, 310, 8'h60);
            else        measure_frame(-1, 8'h00, -1, 8'h00);
            e = sb.pop_front();
            total++;
            if (hi_cnt !== e.hi) begin bad++; $display("FAIL b2b_hi f%0d got %h want %h", f, hi_cnt, e.hi); end
            total++;
            if ({8'(ack_cnt), pend_end} !== {e.acks, e.pend}) begin
                bad++; $display("FAIL b2b_ack f%0d got %0d/%b want %0d/%b", f, ack_cnt, pend_end, e.acks, e.pend);
            end
        end
    endtask

    task automatic test_coincident;
        frame_exp_t e;
        sb.push_back(mk(384, 512, 0, 1020, 1, 1'b1));
        sb.push_back(mk(192, 512, 0, 1020, 1, 1'b0));
        sb.push_back(mk(128, 512, 0, 1020, 0, 1'b0));
        for (int f = 0; f < 3; f++) begin
            if (f == 0) measure_frame(200, 8'h30, FRAME - 2, 8'h20);
            else        measure_frame(-1, 8'h00, -1, 8'h00);
            e = sb.pop_front();
            total++;
            if (hi_cnt !== e.hi) begin bad++; $display("FAIL coin_hi f%0d got %h want %h", f, hi_cnt, e.hi); end
            total++;
            if ({8'(ack_cnt), pend_end} !== {e.acks, e.pend}) begin
                bad++; $display("FAIL coin_ack f%0d got %0d/%b want %0d/%b", f, ack_cnt, pend_end, e.acks, e.pend);
            end
        end
    endtask

    task automatic test_en_low;
        frame_exp_t e;
        en = 1'b0; ch1_val = 8'h33; upd_toggle = ~upd_toggle;
        sb.push_back(mk(128, 204, 0, 1020, 0, 1'b0));
        @(negedge clk);
        total++;
        if ({pwm_out, upd_ack, pending} !== 6'b000001) begin
            bad++; $display("FAIL enlow_capture got pwm,ack,pend=%b want 000001", {pwm_out, upd_ack, pending});
        end
        @(negedge clk);
        total++;
        if ({pwm_out, upd_ack, pending} !== 6'b000010) begin
            bad++; $display("FAIL enlow_load got pwm,ack,pend=%b want 000010", {pwm_out, upd_ack, pending});
        end
        @(negedge clk);
        total++;
        if ({pwm_out, upd_ack} !== 5'b0) begin
            bad++; $display("FAIL enlow_quiet got pwm,ack=%b want 00000", {pwm_out, upd_ack});
        end
        en = 1'b1;
        measure_frame(-1, 8'h00, -1, 8'h00);
        e = sb.pop_front();
        total++;
        if (hi_cnt !== e.hi) begin bad++; $display("FAIL enlow_hi got %h want %h", hi_cnt, e.hi); end
        total++;
        if (first_low[1] != 204) begin bad++; $display("FAIL enlow_ch1_run got %0d want 204", first_low[1]); end
        total++;
        if ({8'(ack_cnt), pend_end} !== {e.acks, e.pend}) begin
            bad++; $display("FAIL enlow_ack got %0d/%b want %0d/%b", ack_cnt, pend_end, e.acks, e.pend);
        end
        total++;
        if (fs_cnt != 1 || fs_idx != FRAME - 1) begin
            bad++; $display("FAIL enlow_restart_fs got cnt=%0d idx=%0d want cnt=1 idx=%0d", fs_cnt, fs_idx, FRAME - 1);
        end
    endtask

    task automatic test_reset_midrun;
        int nz = 0;
        int acks = 0;
        int fs = 0;
        repeat (10) @(negedge clk);
        total++;
        if (pwm_out[3] !== 1'b1) begin bad++; $display("FAIL rstmid_pre got pwm3=%b want 1", pwm_out[3]); end
        ch0_val = 8'h70; upd_toggle = ~upd_toggle;
        @(negedge clk);
        total++;
        if (pending !== 1'b1) begin bad++; $display("FAIL rstmid_pend_pre got %b want 1", pending); end
        rst = 1'b1;
        #1;
        total++;
        if ({pwm_out, frame_start, upd_ack, pending} !== 7'b0) begin
            bad++; $display("FAIL rstmid_async got %b want 0000000", {pwm_out, frame_start, upd_ack, pending});
        end
        upd_toggle = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({pwm_out, frame_start, upd_ack, pending} !== 7'b0) begin
            bad++; $display("FAIL rstmid_hold got %b want 0000000", {pwm_out, frame_start, upd_ack, pending});
        end
        rst = 1'b0;
        for (int i = 0; i < FRAME + 60; i++) begin
            @(negedge clk);
            if (pwm_out !== 4'b0) nz++;
            if (upd_ack) acks++;
            if (frame_start) fs++;
        end
        total++;
        if (nz != 0) begin bad++; $display("FAIL rstmid_pwm_low got %0d high cycles want 0", nz); end
        total++;
        if (acks != 0 || pending !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_load got acks=%0d pend=%b want 0/0", acks, pending);
        end
        total++;
        if (fs != 1) begin bad++; $display("FAIL rstmid_frames got %0d frame_start want 1", fs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_mid_frame();
        test_back_to_back();
        test_coincident();
        test_en_low();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
